// File: rtl/lighthouse_pulse_decoder_pkg.sv
// lighthouse_pkg: shared types and constants for the lighthouse pulse decoder.
//
// Contents:
//   state_e        - pulse FSM states (LOW, HIGH, CLASSIFY)
//   pulse_class_e  - classification result of a measured pulse (SWEEP, SYNC, INVALID)
//   WIDTH_BITS     - width of the pulse-width counter
//   TIME_BITS      - width of the timestamp, reference and age counters
//   classify_width - maps a pulse width onto a pulse class
//   sync_code      - maps a sync pulse width onto its 3-bit code
package lighthouse_pkg;

  localparam int WIDTH_BITS = 13;
  localparam int TIME_BITS  = 20;

  // The width counter sticks at all-ones so very long pulses stay "too long".
  localparam logic [WIDTH_BITS-1:0] WIDTH_SAT = '1;

  typedef enum logic [1:0] {
    LOW,
    HIGH,
    CLASSIFY
  } state_e;

  typedef enum logic [1:0] {
    SWEEP,
    SYNC,
    INVALID
  } pulse_class_e;

  // Sweeps are short; syncs live in one window covering all eight codes
  // including tolerance; everything else is unclassifiable.
  function automatic pulse_class_e classify_width(input int width,
                                                  input int sweepMax,
                                                  input int syncLo,
                                                  input int syncHi);
    if (width <= sweepMax) begin
      return SWEEP;
    end else if ((width >= syncLo) && (width <= syncHi)) begin
      return SYNC;
    end else begin
      return INVALID;
    end
  endfunction

  // Code is the largest k whose lower threshold the width reaches.
  function automatic logic [2:0] sync_code(input int width,
                                           input int syncLo,
                                           input int syncStep);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (width >= syncLo + k * syncStep) begin
        n = 3'(k);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/lighthouse_pulse_decoder_if.sv
// lighthouse_pulse_decoder_if: sensor input and decoded-result outputs of the
// lighthouse pulse decoder.
//
// Signals:
//   sensor       - raw photodiode envelope (asynchronous, high during light)
//   sync_valid   - one-cycle pulse when a sync pulse is classified
//   sync_skip    - decoded skip bit of the last sync
//   sync_data    - decoded data bit of the last sync (OOTX stream)
//   sync_axis    - decoded axis bit of the last sync
//   sweep_valid  - one-cycle pulse when a sweep is timestamped
//   sweep_ticks  - clocks from reference sync rise to sweep rise
//   sweep_axis   - axis of the reference sync used for the sweep
//   pulse_error  - one-cycle pulse on an unclassifiable or unreferenced pulse
//
// Modports:
//   master - drives the sensor, observes the results (environment side)
//   slave  - the decoder itself
interface lighthouse_pulse_decoder_if;
  import lighthouse_pkg::*;

  logic                 sensor;
  logic                 sync_valid;
  logic                 sync_skip;
  logic                 sync_data;
  logic                 sync_axis;
  logic                 sweep_valid;
  logic [TIME_BITS-1:0] sweep_ticks;
  logic                 sweep_axis;
  logic                 pulse_error;

  modport master (
    output sensor,
    input  sync_valid, sync_skip, sync_data, sync_axis,
    input  sweep_valid, sweep_ticks, sweep_axis, pulse_error
  );

  modport slave (
    input  sensor,
    output sync_valid, sync_skip, sync_data, sync_axis,
    output sweep_valid, sweep_ticks, sweep_axis, pulse_error
  );

endinterface

// File: rtl/lighthouse_pulse_decoder_sync_filter.sv
// pulse_sync_filter: brings the asynchronous sensor into the clock domain
// through a 2-FF synchronizer and, optionally, a glitch filter.
//
// Build option: define PULSE_GLITCH_FILTER_EN to enable the glitch filter,
// which changes the output level only after FILTER_DEPTH consecutive equal
// samples. Both edges are delayed by the same amount, so measured widths and
// timestamps are unchanged; pulses shorter than FILTER_DEPTH disappear.
//
// Ports:
//   clock    - system clock
//   reset    - synchronous active-high reset
//   sensor_i - raw asynchronous sensor level
//   level_o  - synchronized (and optionally filtered) sensor level
module pulse_sync_filter
`ifdef PULSE_GLITCH_FILTER_EN
  #(parameter int FILTER_DEPTH = 4)
`endif
  (
  input  logic clock,
  input  logic reset,
  input  logic sensor_i,
  output logic level_o
);

  logic sync1_q;
  logic sync2_q;

  // Two-stage synchronizer; the first stage may go metastable and is never
  // used for anything but feeding the second.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PULSE_GLITCH_FILTER_EN
  localparam int CW = (FILTER_DEPTH > 2) ? $clog2(FILTER_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_DEPTH - 1);

  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Count consecutive samples that disagree with the current level; the
  // level flips on the FILTER_DEPTH-th one, and any agreeing sample restarts
  // the count, so short glitches never reach the output.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= sync2_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;
`else
  assign level_o = sync2_q;
`endif

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// lighthouse_pulse_decoder: measures pulses on a lighthouse photodiode,
// classifies them as sync / sweep / invalid, decodes sync codes and
// timestamps sweeps against the most recent non-skip sync.
//
// Build option: PULSE_GLITCH_FILTER_EN enables the glitch filter inside
// pulse_sync_filter (FILTER_DEPTH samples); undefined means the plain
// synchronizer output is measured directly.
//
// Ports:
//   clock - system clock (50 MHz)
//   reset - synchronous active-high reset
//   pd    - lighthouse_pulse_decoder_if.slave: sensor in, decoded results out
module lighthouse_pulse_decoder
  import lighthouse_pkg::*;
#(
  parameter int SYNC_BASE    = 3125,
  parameter int SYNC_STEP    = 520,
  parameter int SYNC_TOL     = 260,
  parameter int SWEEP_MAX    = 1500,
  parameter int REF_TIMEOUT  = 1000000,
  parameter int FILTER_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  lighthouse_pulse_decoder_if.slave   pd
);

  localparam int SYNC_LO = SYNC_BASE - SYNC_TOL;
  localparam int SYNC_HI = SYNC_BASE + 7 * SYNC_STEP + SYNC_TOL;
  localparam logic [TIME_BITS-1:0] AGE_LIMIT = TIME_BITS'(REF_TIMEOUT);

  logic sig;

`ifdef PULSE_GLITCH_FILTER_EN
  pulse_sync_filter #(
    .FILTER_DEPTH (FILTER_DEPTH)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .sensor_i (pd.sensor),
    .level_o  (sig)
  );
`else
  pulse_sync_filter u_sync (
    .clock    (clock),
    .reset    (reset),
    .sensor_i (pd.sensor),
    .level_o  (sig)
  );
`endif

  state_e                state_q;
  logic                  prev_q;
  logic [WIDTH_BITS-1:0] width_q;
  logic [WIDTH_BITS-1:0] width_d;
  logic [TIME_BITS-1:0]  time_q;
  logic [TIME_BITS-1:0]  rise_q;
  logic [TIME_BITS-1:0]  age_q;
  logic [TIME_BITS-1:0]  age_d;
  logic [TIME_BITS-1:0]  ref_time_q;
  logic                  ref_axis_q;
  logic                  ref_ok_q;
  logic [TIME_BITS-1:0]  ticks_d;
  pulse_class_e          pulse_cls;
  logic [2:0]            code;

  logic                  sync_valid_q;
  logic                  sync_skip_q;
  logic                  sync_data_q;
  logic                  sync_axis_q;
  logic                  sweep_valid_q;
  logic [TIME_BITS-1:0]  sweep_ticks_q;
  logic                  sweep_axis_q;
  logic                  pulse_error_q;

  // Saturating next values for the width and reference-age counters, plus
  // the classification of the width measured so far. Classification is
  // only acted on in the falling-edge cycle, when width_q is final.
  always_comb begin
    width_d   = (width_q == WIDTH_SAT) ? width_q : width_q + {{(WIDTH_BITS-1){1'b0}}, 1'b1};
    age_d     = (age_q == AGE_LIMIT) ? age_q : age_q + {{(TIME_BITS-1){1'b0}}, 1'b1};
    ticks_d   = rise_q - ref_time_q;
    pulse_cls = classify_width(int'(width_q), SWEEP_MAX, SYNC_LO, SYNC_HI);
    code      = sync_code(int'(width_q), SYNC_LO, SYNC_STEP);
  end

  // Pulse FSM with registered outputs. The result is registered on the
  // falling-edge cycle, so it is visible exactly while the FSM sits in
  // CLASSIFY. A later assignment in this block overrides the defaults at
  // its top (valid strobes cleared, age advancing, reference expiring).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= LOW;
      prev_q        <= 1'b0;
      width_q       <= '0;
      time_q        <= '0;
      rise_q        <= '0;
      age_q         <= '0;
      ref_time_q    <= '0;
      ref_axis_q    <= 1'b0;
      ref_ok_q      <= 1'b0;
      sync_valid_q  <= 1'b0;
      sync_skip_q   <= 1'b0;
      sync_data_q   <= 1'b0;
      sync_axis_q   <= 1'b0;
      sweep_valid_q <= 1'b0;
      sweep_ticks_q <= '0;
      sweep_axis_q  <= 1'b0;
      pulse_error_q <= 1'b0;
    end else begin
      prev_q        <= sig;
      time_q        <= time_q + {{(TIME_BITS-1){1'b0}}, 1'b1};
      age_q         <= age_d;
      sync_valid_q  <= 1'b0;
      sweep_valid_q <= 1'b0;
      pulse_error_q <= 1'b0;

      if (age_q == AGE_LIMIT) begin
        ref_ok_q <= 1'b0;
      end

      unique case (state_q)
        LOW: begin
          if (sig && !prev_q) begin
            state_q <= HIGH;
            width_q <= {{(WIDTH_BITS-1){1'b0}}, 1'b1};
            rise_q  <= time_q;
          end
        end

        HIGH: begin
          if (!sig) begin
            state_q <= CLASSIFY;
            unique case (pulse_cls)
              SWEEP: begin
                if (ref_ok_q) begin
                  sweep_valid_q <= 1'b1;
                  sweep_ticks_q <= ticks_d;
                  sweep_axis_q  <= ref_axis_q;
                end else begin
                  pulse_error_q <= 1'b1;
                end
              end
              SYNC: begin
                sync_valid_q <= 1'b1;
                sync_skip_q  <= code[2];
                sync_data_q  <= code[1];
                sync_axis_q  <= code[0];
                // Only non-skip syncs mark the start of a sweep.
                if (!code[2]) begin
                  ref_time_q <= rise_q;
                  ref_axis_q <= code[0];
                  ref_ok_q   <= 1'b1;
                  age_q      <= '0;
                end
              end
              default: begin
                pulse_error_q <= 1'b1;
              end
            endcase
          end else begin
            width_q <= width_d;
          end
        end

        CLASSIFY: begin
          state_q <= LOW;
        end

        default: begin
          state_q <= LOW;
        end
      endcase
    end
  end

  assign pd.sync_valid  = sync_valid_q;
  assign pd.sync_skip   = sync_skip_q;
  assign pd.sync_data   = sync_data_q;
  assign pd.sync_axis   = sync_axis_q;
  assign pd.sweep_valid = sweep_valid_q;
  assign pd.sweep_ticks = sweep_ticks_q;
  assign pd.sweep_axis  = sweep_axis_q;
  assign pd.pulse_error = pulse_error_q;

endmodule
